// File: rtl/npc_ctrl_fsm.sv
// npc_ctrl_fsm: multi-cycle fetch/decode/execute/mem/writeback sequencer for the
// TRM core. Owns the PC, the instruction/data memory handshakes, the retire
// counter and the halt logic; decoder and EXU results arrive as status inputs.
module npc_ctrl_fsm #(
  parameter logic [31:0] RESET_PC = 32'h8000_0000,
  parameter int unsigned TIMEOUT  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instr_q,
  input  logic        dec_illegal,
  input  logic        dec_ebreak,
  input  logic        dec_mem_en,
  input  logic        dec_mem_we,
  input  logic        dec_reg_we,
  input  logic [31:0] pc_next,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  output logic        rf_we,
  output logic [31:0] pc,
  output logic [2:0]  state,
  output logic [31:0] instret,
  output logic        halted,
  output logic [2:0]  halt_code
);

  localparam int unsigned XLEN   = 32;
  localparam int unsigned CNT_W  = 8;
  localparam int unsigned CODE_W = 3;

  localparam logic [CODE_W-1:0] HC_NONE     = CODE_W'(0);
  localparam logic [CODE_W-1:0] HC_EBREAK   = CODE_W'(1);
  localparam logic [CODE_W-1:0] HC_ILLEGAL  = CODE_W'(2);
  localparam logic [CODE_W-1:0] HC_TIMEOUT  = CODE_W'(3);
  localparam logic [CODE_W-1:0] HC_MISALIGN = CODE_W'(4);

  typedef enum logic [2:0] {
    S_FETCH_REQ  = 3'd0,
    S_FETCH_WAIT = 3'd1,
    S_DECODE     = 3'd2,
    S_EXECUTE    = 3'd3,
    S_MEM        = 3'd4,
    S_WRITEBACK  = 3'd5,
    S_HALT       = 3'd6
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [CNT_W-1:0]    cnt_q;
  logic [CNT_W-1:0]    cnt_nxt;
  logic [XLEN-1:0]     pc_nxt;
  logic [XLEN-1:0]     instr_nxt;
  logic [XLEN-1:0]     instret_nxt;
  logic [CODE_W-1:0]   code_nxt;
  logic                halted_nxt;
  logic                timeout_hit;

  assign state     = state_q;
  assign imem_addr = pc;

  // The wait budget is spent when this cycle would be the TIMEOUT-th without a handshake.
  assign timeout_hit = (cnt_q + CNT_W'(1)) == CNT_W'(TIMEOUT);

  // Next-state, datapath updates and request/strobe decode.
  always_comb begin
    state_nxt   = state_q;
    pc_nxt      = pc;
    instr_nxt   = instr_q;
    instret_nxt = instret;
    code_nxt    = halt_code;
    cnt_nxt     = cnt_q;
    imem_req    = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;

    unique case (state_q)
      S_FETCH_REQ: begin
        // State is forced to FETCH_REQ during reset; keep the request quiet then.
        imem_req = rst_n;
        if (imem_gnt && imem_rvalid) begin
          instr_nxt = imem_rdata;
          state_nxt = S_DECODE;
        end else if (imem_gnt) begin
          state_nxt = S_FETCH_WAIT;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          code_nxt  = HC_TIMEOUT;
        end
      end

      S_FETCH_WAIT: begin
        if (imem_rvalid) begin
          instr_nxt = imem_rdata;
          state_nxt = S_DECODE;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          code_nxt  = HC_TIMEOUT;
        end
      end

      S_DECODE: begin
        if (dec_illegal) begin
          state_nxt = S_HALT;
          code_nxt  = HC_ILLEGAL;
        end else if (dec_ebreak) begin
          state_nxt = S_HALT;
          code_nxt  = HC_EBREAK;
        end else begin
          state_nxt = S_EXECUTE;
        end
      end

      S_EXECUTE: begin
        state_nxt = dec_mem_en ? S_MEM : S_WRITEBACK;
      end

      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = dec_mem_we;
        if (dmem_ready) begin
          state_nxt = S_WRITEBACK;
        end else if (timeout_hit) begin
          state_nxt = S_HALT;
          code_nxt  = HC_TIMEOUT;
        end
      end

      S_WRITEBACK: begin
        if (pc_next[1:0] != 2'b00) begin
          state_nxt = S_HALT;
          code_nxt  = HC_MISALIGN;
        end else begin
          rf_we       = dec_reg_we;
          pc_nxt      = pc_next;
          instret_nxt = instret + XLEN'(1);
          state_nxt   = S_FETCH_REQ;
        end
      end

      S_HALT: begin
        state_nxt = S_HALT;
      end

      default: begin
        state_nxt = S_HALT;
      end
    endcase

    // Wait counter restarts on every state change and only runs in handshake states.
    if (state_nxt != state_q) begin
      cnt_nxt = '0;
    end else if ((state_q == S_FETCH_REQ) || (state_q == S_FETCH_WAIT) || (state_q == S_MEM)) begin
      cnt_nxt = cnt_q + CNT_W'(1);
    end
  end

  assign halted_nxt = (state_nxt == S_HALT);

  // State and architectural registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH_REQ;
      pc        <= RESET_PC;
      instr_q   <= '0;
      instret   <= '0;
      halted    <= 1'b0;
      halt_code <= HC_NONE;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_nxt;
      pc        <= pc_nxt;
      instr_q   <= instr_nxt;
      instret   <= instret_nxt;
      halted    <= halted_nxt;
      halt_code <= code_nxt;
      cnt_q     <= cnt_nxt;
    end
  end

endmodule

// File: tb/tb_npc_ctrl_fsm.sv
// Testbench for npc_ctrl_fsm: directed vector table, randomized instruction
// stream against a transaction-level model, and hand-written reset/halt sequences.
module tb_npc_ctrl_fsm;

  localparam int unsigned TO = 16;
  localparam logic [31:0] RPC = 32'h8000_0000;

  logic        clk;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic [31:0] instr_q;
  logic        dec_illegal;
  logic        dec_ebreak;
  logic        dec_mem_en;
  logic        dec_mem_we;
  logic        dec_reg_we;
  logic [31:0] pc_next;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ready;
  logic        rf_we;
  logic [31:0] pc;
  logic [2:0]  state;
  logic [31:0] instret;
  logic        halted;
  logic [2:0]  halt_code;

  npc_ctrl_fsm #(.RESET_PC(RPC), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_q(instr_q),
    .dec_illegal(dec_illegal), .dec_ebreak(dec_ebreak), .dec_mem_en(dec_mem_en),
    .dec_mem_we(dec_mem_we), .dec_reg_we(dec_reg_we), .pc_next(pc_next),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .rf_we(rf_we), .pc(pc), .state(state), .instret(instret),
    .halted(halted), .halt_code(halt_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One instruction's environment: bus delays and decoder/EXU status.
  typedef struct {
    int          g;       // request cycles without gnt before gnt
    int          r;       // cycles after gnt until rvalid (0 = same cycle)
    int          m;       // MEM cycles without ready before ready
    bit          illegal;
    bit          ebreak;
    bit          mem_en;
    bit          mem_we;
    bit          reg_we;
    logic [31:0] pc_next;
  } scen_t;

  typedef struct {
    int          cycles;
    int          rf;
    int          dreq;
    int          dwe;
    logic [31:0] addr;
    logic [31:0] rdata;
    bit          ended;
  } res_t;

  typedef struct {
    int          cycles;
    int          rf;
    int          dreq;
    int          dwe;
    logic [2:0]  code;
    bit          fetched;
    bit          retire;
  } exp_t;

  typedef struct {
    scen_t       s;
    int          cycles;
    int          rf;
    int          dreq;
    logic [2:0]  code;
    logic [31:0] pc;
    logic [31:0] instret;
  } vec_t;

  int total = 0;
  int bad   = 0;
  logic [31:0] m_pc;
  logic [31:0] m_instret;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    dec_illegal = 1'b0; dec_ebreak = 1'b0; dec_mem_en = 1'b0;
    dec_mem_we = 1'b0; dec_reg_we = 1'b0; pc_next = '0; dmem_ready = 1'b0;
  endtask

  task automatic do_reset(input bit chk);
    @(negedge clk);
    rst_n = 1'b0;
    clear_inputs();
    #1;
    if (chk) begin
      check("rst_state", 32'(state), 32'd0);
      check("rst_pc", pc, RPC);
      check("rst_instr_q", instr_q, 32'd0);
      check("rst_instret", instret, 32'd0);
      check("rst_halted", 32'(halted), 32'd0);
      check("rst_halt_code", 32'(halt_code), 32'd0);
      check("rst_strobes", {28'd0, imem_req, dmem_req, dmem_we, rf_we}, 32'd0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  // Reactive bus responder for one instruction; returns at the first cycle of the
  // next instruction's fetch, or when the core reports halted.
  task automatic run_instr(input scen_t s, output res_t o);
    int  req_n;
    int  since_gnt;
    int  mem_n;
    bit  granted;
    bit  fetched;
    int  guard;
    o.cycles = 0; o.rf = 0; o.dreq = 0; o.dwe = 0; o.addr = '0; o.ended = 1'b0;
    o.rdata = $urandom;
    req_n = 0; since_gnt = 0; mem_n = 0; granted = 1'b0; fetched = 1'b0; guard = 0;
    imem_rdata  = o.rdata;
    dec_illegal = s.illegal; dec_ebreak = s.ebreak; dec_mem_en = s.mem_en;
    dec_mem_we  = s.mem_we;  dec_reg_we = s.reg_we; pc_next = s.pc_next;
    while (!o.ended && guard < 400) begin
      guard++;
      if (halted || (imem_req && granted)) begin
        o.ended = 1'b1;
      end else begin
        imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_ready = 1'b0;
        if (imem_req) begin
          if (req_n == 0) o.addr = imem_addr;
          if (req_n == s.g) begin
            imem_gnt = 1'b1;
            granted  = 1'b1;
            if (s.r == 0) begin imem_rvalid = 1'b1; fetched = 1'b1; end
          end
          req_n++;
        end else if (granted && !fetched) begin
          since_gnt++;
          if (since_gnt == s.r) begin imem_rvalid = 1'b1; fetched = 1'b1; end
        end
        if (dmem_req) begin
          if (mem_n == s.m) dmem_ready = 1'b1;
          mem_n++;
        end
        #1;
        o.cycles++;
        if (rf_we) o.rf++;
        if (dmem_req) o.dreq++;
        if (dmem_we) o.dwe++;
        @(negedge clk);
      end
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0; dmem_ready = 1'b0;
    check("instr_end_seen", 32'(o.ended), 32'd1);
  endtask

  // Transaction-level outcome of one instruction from the sequencing rules.
  function automatic exp_t model(input scen_t s);
    exp_t e;
    e.cycles = 0; e.rf = 0; e.dreq = 0; e.dwe = 0; e.code = 3'd0;
    e.fetched = 1'b0; e.retire = 1'b0;
    if (s.g >= int'(TO)) begin e.cycles = TO; e.code = 3'd3; return e; end
    e.cycles = s.g + 1;
    if (s.r != 0) begin
      if (s.r - 1 >= int'(TO)) begin e.cycles += TO; e.code = 3'd3; return e; end
      e.cycles += s.r;
    end
    e.fetched = 1'b1;
    e.cycles += 1;
    if (s.illegal) begin e.code = 3'd2; return e; end
    if (s.ebreak)  begin e.code = 3'd1; return e; end
    e.cycles += 1;
    if (s.mem_en) begin
      if (s.m >= int'(TO)) begin
        e.cycles += TO; e.dreq = TO; e.dwe = s.mem_we ? int'(TO) : 0; e.code = 3'd3;
        return e;
      end
      e.cycles += s.m + 1; e.dreq = s.m + 1; e.dwe = s.mem_we ? s.m + 1 : 0;
    end
    e.cycles += 1;
    if (s.pc_next[1:0] != 2'b00) begin e.code = 3'd4; return e; end
    e.rf = s.reg_we ? 1 : 0;
    e.retire = 1'b1;
    return e;
  endfunction

  function automatic vec_t mk(input int g, input int r, input int m, input bit ill,
                              input bit ebk, input bit men, input bit mwe, input bit rwe,
                              input logic [31:0] pcn, input int cyc, input int rf,
                              input int dreq, input logic [2:0] code,
                              input logic [31:0] epc, input logic [31:0] eret);
    vec_t v;
    v.s.g = g; v.s.r = r; v.s.m = m; v.s.illegal = ill; v.s.ebreak = ebk;
    v.s.mem_en = men; v.s.mem_we = mwe; v.s.reg_we = rwe; v.s.pc_next = pcn;
    v.cycles = cyc; v.rf = rf; v.dreq = dreq; v.code = code; v.pc = epc; v.instret = eret;
    return v;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t  tbl [12];
    res_t  o;
    exp_t  e;
    scen_t s;
    int    cnt;

    tbl[0]  = mk(0,   1,  0, 0,0,0,0,1, 32'h8000_0004,  5,1, 0, 3'd0, 32'h8000_0004, 1);
    tbl[1]  = mk(0,   1,  3, 0,0,1,1,0, 32'h8000_0004,  9,0, 4, 3'd0, 32'h8000_0004, 1);
    tbl[2]  = mk(0,   0,  0, 0,0,1,0,1, 32'h8000_0010,  5,1, 1, 3'd0, 32'h8000_0010, 1);
    tbl[3]  = mk(0,   1,  0, 0,1,0,0,1, 32'h8000_0004,  3,0, 0, 3'd1, 32'h8000_0000, 0);
    tbl[4]  = mk(0,   1,  0, 1,1,0,0,1, 32'h8000_0004,  3,0, 0, 3'd2, 32'h8000_0000, 0);
    tbl[5]  = mk(100, 1,  0, 0,0,0,0,1, 32'h8000_0004, 16,0, 0, 3'd3, 32'h8000_0000, 0);
    tbl[6]  = mk(15,  1,  0, 0,0,0,0,1, 32'h8000_0004, 20,1, 0, 3'd0, 32'h8000_0004, 1);
    tbl[7]  = mk(0,  16,  0, 0,0,0,0,1, 32'h8000_0004, 20,1, 0, 3'd0, 32'h8000_0004, 1);
    tbl[8]  = mk(0,  17,  0, 0,0,0,0,1, 32'h8000_0004, 17,0, 0, 3'd3, 32'h8000_0000, 0);
    tbl[9]  = mk(0,   1, 16, 0,0,1,1,0, 32'h8000_0004, 20,0,16, 3'd3, 32'h8000_0000, 0);
    tbl[10] = mk(0,   1, 15, 0,0,1,0,1, 32'h8000_0004, 21,1,16, 3'd0, 32'h8000_0004, 1);
    tbl[11] = mk(0,   1,  0, 0,0,0,0,1, 32'h8000_0006,  5,0, 0, 3'd4, 32'h8000_0000, 0);

    rst_n = 1'b0;
    clear_inputs();
    do_reset(1'b1);

    // Directed vectors, each from a fresh reset.
    for (int i = 0; i < 12; i++) begin
      do_reset(1'b0);
      run_instr(tbl[i].s, o);
      check($sformatf("v%0d_cycles", i), 32'(o.cycles), 32'(tbl[i].cycles));
      check($sformatf("v%0d_rf_we", i), 32'(o.rf), 32'(tbl[i].rf));
      check($sformatf("v%0d_dmem_req", i), 32'(o.dreq), 32'(tbl[i].dreq));
      check($sformatf("v%0d_dmem_we", i), 32'(o.dwe), tbl[i].s.mem_we ? 32'(tbl[i].dreq) : 32'd0);
      check($sformatf("v%0d_halted", i), 32'(halted), (tbl[i].code != 3'd0) ? 32'd1 : 32'd0);
      check($sformatf("v%0d_halt_code", i), 32'(halt_code), 32'(tbl[i].code));
      check($sformatf("v%0d_pc", i), pc, tbl[i].pc);
      check($sformatf("v%0d_instret", i), instret, tbl[i].instret);
      check($sformatf("v%0d_imem_addr", i), o.addr, RPC);
      if ((tbl[i].code != 3'd3) || tbl[i].s.mem_en)
        check($sformatf("v%0d_instr_q", i), instr_q, o.rdata);
    end

    // Halt is sticky: no requests or write enables afterwards.
    do_reset(1'b0);
    run_instr(tbl[3].s, o);
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      imem_gnt = 1'b1; imem_rvalid = 1'b1; dmem_ready = 1'b1;
      #1;
      if (imem_req || dmem_req || dmem_we || rf_we) cnt++;
    end
    clear_inputs();
    check("halt_quiet", 32'(cnt), 32'd0);
    check("halt_state", 32'(state), 32'd6);
    check("halt_sticky", 32'(halted), 32'd1);
    check("halt_code_hold", 32'(halt_code), 32'd1);

    // Reset asserted mid-MEM drops the data request immediately.
    do_reset(1'b0);
    run_instr(tbl[0].s, o);
    check("pre_mid_instret", instret, 32'd1);
    dec_mem_en = 1'b1; dec_mem_we = 1'b1; dec_reg_we = 1'b0; pc_next = pc + 32'd4;
    cnt = 0;
    for (int k = 0; k < 30 && cnt == 0; k++) begin
      imem_gnt = imem_req; imem_rvalid = imem_req; dmem_ready = 1'b0;
      #1;
      if (dmem_req) cnt = 1;
      else @(negedge clk);
    end
    imem_gnt = 1'b0; imem_rvalid = 1'b0;
    check("mid_mem_reached", 32'(cnt), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_dmem_req", 32'(dmem_req), 32'd0);
    check("mid_rst_dmem_we", 32'(dmem_we), 32'd0);
    check("mid_rst_imem_req", 32'(imem_req), 32'd0);
    check("mid_rst_state", 32'(state), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_state", 32'(state), 32'd0);
    check("mid_rel_pc", pc, RPC);
    check("mid_rel_instret", instret, 32'd0);
    clear_inputs();

    // Randomized instruction stream against the model.
    do_reset(1'b0);
    m_pc = RPC;
    m_instret = '0;
    for (int n = 0; n < 80; n++) begin
      s.g = ($urandom_range(0, 7) == 0) ? int'(TO) - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      s.r = ($urandom_range(0, 7) == 0) ? int'(TO) + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      s.m = ($urandom_range(0, 7) == 0) ? int'(TO) - 1 + int'($urandom_range(0, 1)) : int'($urandom_range(0, 3));
      s.illegal = ($urandom_range(0, 15) == 0);
      s.ebreak  = ($urandom_range(0, 15) == 0);
      s.mem_en  = ($urandom_range(0, 2) == 0);
      s.mem_we  = s.mem_en && ($urandom_range(0, 1) == 1);
      s.reg_we  = ($urandom_range(0, 1) == 1);
      if ($urandom_range(0, 3) == 0) s.pc_next = $urandom & 32'hFFFF_FFFC;
      else s.pc_next = m_pc + 32'd4;
      if ($urandom_range(0, 11) == 0) s.pc_next[1:0] = 2'($urandom_range(1, 3));
      e = model(s);
      run_instr(s, o);
      check($sformatf("r%0d_cycles", n), 32'(o.cycles), 32'(e.cycles));
      check($sformatf("r%0d_rf_we", n), 32'(o.rf), 32'(e.rf));
      check($sformatf("r%0d_dmem_req", n), 32'(o.dreq), 32'(e.dreq));
      check($sformatf("r%0d_dmem_we", n), 32'(o.dwe), 32'(e.dwe));
      check($sformatf("r%0d_imem_addr", n), o.addr, m_pc);
      if (e.retire) begin
        m_pc = s.pc_next;
        m_instret = m_instret + 32'd1;
      end
      check($sformatf("r%0d_pc", n), pc, m_pc);
      check($sformatf("r%0d_instret", n), instret, m_instret);
      check($sformatf("r%0d_halted", n), 32'(halted), (e.code != 3'd0) ? 32'd1 : 32'd0);
      check($sformatf("r%0d_halt_code", n), 32'(halt_code), 32'(e.code));
      if (e.fetched) check($sformatf("r%0d_instr_q", n), instr_q, o.rdata);
      if (e.code != 3'd0) begin
        do_reset(1'b0);
        m_pc = RPC;
        m_instret = '0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
